// File: rtl/sfu_stream_pkg.sv
// Shared types and constants for the SFU stream master: FSM states, CSR word
// layout and the func bit that selects the start-driven softmax path.
package sfu_stream_pkg;

  localparam int DATA_WIDTH      = 512;
  localparam int NUM_SOFTMAX_MAX = 512;
  localparam int TIMEOUT_CYCLES  = 4096;

  localparam int FUNC_MSB         = 31;
  localparam int FUNC_LSB         = 26;
  localparam int LEN_MSB          = 25;
  localparam int LEN_LSB          = 20;
  localparam int SOFTMAX_FUNC_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_START,
    ST_FEED,
    ST_COLLECT
  } state_e;

  function automatic logic [31:0] csr_word(input logic [5:0] func, input logic [5:0] len);
    csr_word                   = '0;
    csr_word[FUNC_MSB:FUNC_LSB] = func;
    csr_word[LEN_MSB:LEN_LSB]   = len;
  endfunction

endpackage

// File: rtl/sfu_stream_master_if.sv
// Job, upstream, SFU and downstream signals of the SFU stream master; the
// master modport is the block's view, slave is its environment's view.
interface sfu_stream_master_if #(
  parameter int DataWidth = 512
) ();

  logic                 job_valid_i;
  logic                 job_ready_o;
  logic [5:0]           job_func_i;
  logic [5:0]           job_len_i;
  logic                 src_valid_i;
  logic                 src_ready_o;
  logic [DataWidth-1:0] src_data_i;
  logic                 sfu_in_valid_o;
  logic                 sfu_in_ready_i;
  logic [DataWidth-1:0] sfu_in_bits_o;
  logic                 sfu_out_valid_i;
  logic                 sfu_out_ready_o;
  logic [DataWidth-1:0] sfu_out_bits_i;
  logic [31:0]          sfu_csr_o;
  logic                 sfu_start_o;
  logic                 sfu_busy_i;
  logic                 dst_valid_o;
  logic                 dst_ready_i;
  logic [DataWidth-1:0] dst_data_o;
  logic                 done_o;
  logic                 err_overflow_o;
  logic                 err_timeout_o;

  modport master (
    input  job_valid_i, job_func_i, job_len_i, src_valid_i, src_data_i,
           sfu_in_ready_i, sfu_out_valid_i, sfu_out_bits_i, sfu_busy_i, dst_ready_i,
    output job_ready_o, src_ready_o, sfu_in_valid_o, sfu_in_bits_o, sfu_out_ready_o,
           sfu_csr_o, sfu_start_o, dst_valid_o, dst_data_o, done_o,
           err_overflow_o, err_timeout_o
  );

  modport slave (
    output job_valid_i, job_func_i, job_len_i, src_valid_i, src_data_i,
           sfu_in_ready_i, sfu_out_valid_i, sfu_out_bits_i, sfu_busy_i, dst_ready_i,
    input  job_ready_o, src_ready_o, sfu_in_valid_o, sfu_in_bits_o, sfu_out_ready_o,
           sfu_csr_o, sfu_start_o, dst_valid_o, dst_data_o, done_o,
           err_overflow_o, err_timeout_o
  );

endinterface

// File: rtl/sfu_result_fifo.sv
// First-word fall-through synchronous FIFO that absorbs SFU result beats.
// Pushes while full and pops while empty are ignored.
module sfu_result_fifo #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 512,
  localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == CntW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need a defined value.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PtrW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PtrW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sfu_stream_master.sv
// Programs the SFU CSR, pulses start, streams input vectors into the SFU and
// collects every result beat into a local FIFO that drains to the consumer.
module sfu_stream_master
  import sfu_stream_pkg::*;
#(
  parameter int DataWidth     = DATA_WIDTH,
  parameter int NumSoftmaxMax = NUM_SOFTMAX_MAX,
  parameter int PeNum         = DataWidth / 32,
  parameter int MaxBeats      = NumSoftmaxMax / PeNum,
  parameter int TimeoutCycles = TIMEOUT_CYCLES
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  sfu_stream_master_if.master  bus
);

  localparam int CntW = $clog2(MaxBeats + 1);
  localparam int WdW  = $clog2(TimeoutCycles);

  state_e          state_q, state_d;
  logic [5:0]      func_q, len_q, tx_cnt_q, rx_cnt_q;
  logic [31:0]     csr_q;
  logic [WdW-1:0]  wd_q;
  logic            err_ovf_q, err_to_q;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            accept, feeding, tx_open, in_fire, rx_fire, softmax;
  logic            start, done, timeout_hit;

  // A job is only taken when every one of its result beats is guaranteed a FIFO slot.
  assign bus.job_ready_o = (state_q == ST_IDLE) && (bus.job_len_i != '0) &&
                           (int'(bus.job_len_i) <= MaxBeats - int'(fifo_count));
  assign accept  = bus.job_valid_i & bus.job_ready_o;
  assign softmax = func_q[SOFTMAX_FUNC_BIT];

  assign feeding            = (state_q == ST_FEED);
  assign tx_open            = (tx_cnt_q < len_q);
  assign bus.sfu_in_valid_o = feeding & bus.src_valid_i & tx_open;
  assign bus.src_ready_o    = feeding & bus.sfu_in_ready_i & tx_open;
  assign bus.sfu_in_bits_o  = feeding ? bus.src_data_i : '0;
  assign in_fire            = bus.sfu_in_valid_o & bus.sfu_in_ready_i;

  assign bus.sfu_out_ready_o = ~fifo_full;
  assign rx_fire             = bus.sfu_out_valid_i & ~fifo_full;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    done        = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CFG;
      ST_CFG:   state_d = ST_START;
      ST_START: begin
        start   = softmax;
        state_d = ST_FEED;
      end
      ST_FEED:  if (in_fire && (tx_cnt_q == len_q - 6'd1)) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if ((rx_cnt_q == len_q) && !(softmax && bus.sfu_busy_i)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (!rx_fire && (wd_q == WdW'(TimeoutCycles - 1))) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      func_q    <= '0;
      len_q     <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      csr_q     <= '0;
      wd_q      <= '0;
      err_ovf_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        csr_q    <= csr_word(bus.job_func_i, bus.job_len_i);
        func_q   <= bus.job_func_i;
        len_q    <= bus.job_len_i;
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end else begin
        if (in_fire) tx_cnt_q <= tx_cnt_q + 1'b1;
        if (rx_fire && (feeding || state_q == ST_COLLECT)) rx_cnt_q <= rx_cnt_q + 1'b1;
      end
      // Watchdog only runs in COLLECT and restarts on every result beat.
      wd_q      <= (state_q != ST_COLLECT || rx_fire) ? '0 : wd_q + 1'b1;
      err_ovf_q <= err_ovf_q | (bus.sfu_out_valid_i & fifo_full);
      err_to_q  <= err_to_q | timeout_hit;
    end
  end

  assign bus.sfu_csr_o      = csr_q;
  assign bus.sfu_start_o    = start;
  assign bus.done_o         = done;
  assign bus.err_overflow_o = err_ovf_q;
  assign bus.err_timeout_o  = err_to_q;
  assign bus.dst_valid_o    = ~fifo_empty;

  sfu_result_fifo #(
    .DEPTH (MaxBeats),
    .WIDTH (DataWidth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (bus.sfu_out_valid_i),
    .wr_data (bus.sfu_out_bits_i),
    .pop     (bus.dst_ready_i),
    .rd_data (bus.dst_data_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_sfu_stream_master.sv
// Directed job sequence with random vector data; a behavioural SFU and a
// result queue in the bench predict every downstream beat.
module tb_sfu_stream_master;

  localparam int DW = 512;
  localparam int TO = 4096;

  typedef logic [DW-1:0] beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sfu_stream_master_if #(.DataWidth(DW)) bus ();

  sfu_stream_master dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  beat_t exp_q[$];
  beat_t sfu_q[$];
  int    sfu_due[$];
  beat_t cur_src;
  bit    src_toggle, dst_rdy_en, emit_en, busy_force, inject, accepted, fin;
  int    stall_at, stall_left, busy_tail;
  int    n_src, n_in, n_dst, n_start, n_done, acc_cyc, start_cyc, last_in_cyc, end_cyc;

  // SFU stand-in: rotate lanes by one and scramble with a fixed pattern.
  function automatic beat_t sfu_fn(input beat_t x);
    return {x[DW-33:0], x[DW-1:DW-32]} ^ {16{32'hA5C3_5A3C}};
  endfunction

  function automatic beat_t rand_beat();
    beat_t r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input beat_t got, input beat_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive the environment in the low phase, record the handshakes
  // that the coming rising edge will complete, return just after that edge.
  task automatic tick();
    bit model_emit;
    @(negedge clk);
    bus.src_valid_i = src_toggle ? cyc[0] : 1'b1;
    bus.src_data_i  = cur_src;
    if (stall_at >= 0 && n_in == stall_at) begin
      stall_left = 3;
      stall_at   = -1;
    end
    bus.sfu_in_ready_i = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    model_emit = 1'b0;
    if (inject) begin
      bus.sfu_out_valid_i = 1'b1;
      bus.sfu_out_bits_i  = rand_beat();
    end else if (emit_en && sfu_q.size() > 0 && sfu_due[0] <= cyc) begin
      bus.sfu_out_valid_i = 1'b1;
      bus.sfu_out_bits_i  = sfu_q[0];
      model_emit          = 1'b1;
    end else begin
      bus.sfu_out_valid_i = 1'b0;
      bus.sfu_out_bits_i  = '0;
    end
    bus.sfu_busy_i  = busy_force | (sfu_q.size() > 0) | (busy_tail > 0);
    bus.dst_ready_i = dst_rdy_en;
    #1;
    if (bus.job_valid_i && bus.job_ready_o) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
    end
    if (bus.sfu_in_valid_o && bus.sfu_in_ready_i) begin
      sfu_q.push_back(sfu_fn(bus.sfu_in_bits_o));
      sfu_due.push_back(cyc + 3);
      n_in++;
      last_in_cyc = cyc;
    end
    if (bus.src_valid_i && bus.src_ready_o) begin
      exp_q.push_back(sfu_fn(cur_src));
      n_src++;
      cur_src = rand_beat();
    end
    if (model_emit) begin
      void'(sfu_q.pop_front());
      void'(sfu_due.pop_front());
      if (sfu_q.size() == 0) busy_tail = 2;
    end else if (busy_tail > 0) begin
      busy_tail--;
    end
    inject = 1'b0;
    if (bus.dst_valid_o && bus.dst_ready_i) begin
      n_dst++;
      check("dst_beat_expected", longint'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_beat("dst_data", bus.dst_data_o, exp_q.pop_front());
    end
    if (bus.sfu_start_o) begin
      n_start++;
      start_cyc = cyc;
    end
    if (bus.done_o) n_done++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [5:0] func, input logic [5:0] len, input int budget);
    n_src = 0; n_in = 0; n_dst = 0; n_start = 0; n_done = 0;
    accepted = 1'b0; start_cyc = -1;
    bus.job_func_i  = func;
    bus.job_len_i   = len;
    bus.job_valid_i = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) tick();
    bus.job_valid_i = 1'b0;
    bus.job_len_i   = '0;
    check("job_accepted", accepted, 1);
    fin = 1'b0;
    for (int i = 0; i < budget && !fin; i++) begin
      tick();
      if (n_done > 0 || bus.err_timeout_o) fin = 1'b1;
    end
    end_cyc = cyc - 1;
    check("job_finished", fin, 1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() > 0 || bus.dst_valid_o); i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bus.job_valid_i = 1'b0; bus.job_func_i = '0; bus.job_len_i = '0;
    bus.src_valid_i = 1'b0; bus.src_data_i = '0; bus.sfu_in_ready_i = 1'b0;
    bus.sfu_out_valid_i = 1'b0; bus.sfu_out_bits_i = '0; bus.sfu_busy_i = 1'b0;
    bus.dst_ready_i = 1'b0;
    src_toggle = 0; dst_rdy_en = 1; emit_en = 1; busy_force = 0; inject = 0;
    stall_at = -1; stall_left = 0; busy_tail = 0;
    cur_src = rand_beat();

    // Reset values
    repeat (3) tick();
    check("rst_ctrl_outputs", {bus.job_ready_o, bus.src_ready_o, bus.sfu_in_valid_o, bus.sfu_start_o,
                               bus.done_o, bus.dst_valid_o, bus.err_overflow_o, bus.err_timeout_o}, 0);
    check("rst_csr", bus.sfu_csr_o, 0);
    check("rst_out_ready_fifo_empty", bus.sfu_out_ready_o, 1);
    rst_n = 1'b1;
    tick();

    // Length acceptance bounds
    bus.job_len_i = 6'd0;  tick(); check("len0_ready", bus.job_ready_o, 0);
    bus.job_len_i = 6'd33; tick(); check("len33_ready", bus.job_ready_o, 0);
    bus.job_len_i = 6'd32; tick(); check("len32_ready", bus.job_ready_o, 1);

    // Softmax len=4, free-flowing source and sink
    run_job(6'b010011, 6'd4, 500);
    drain(200);
    check("t1_csr", bus.sfu_csr_o, {6'b010011, 6'd4, 20'd0});
    check("t1_start_latency", start_cyc - acc_cyc, 2);
    check("t1_start_count", n_start, 1);
    check("t1_in_beats", n_in, 4);
    check("t1_dst_beats", n_dst, 4);
    check("t1_done_count", n_done, 1);

    // len=32 with gappy source and a 3-cycle SFU input stall
    src_toggle = 1; stall_at = 10;
    run_job(6'b010000, 6'd32, 2000);
    drain(500);
    src_toggle = 0;
    check("t2_src_beats", n_src, 32);
    check("t2_in_beats", n_in, 32);
    check("t2_dst_beats", n_dst, 32);
    check("t2_done_count", n_done, 1);

    // Downstream stalled for a whole len=32 job
    dst_rdy_en = 0;
    run_job(6'b010001, 6'd32, 2000);
    repeat (3) tick();
    check("t3_no_overflow", bus.err_overflow_o, 0);
    check("t3_results_held", exp_q.size(), 32);
    check("t3_dst_valid", bus.dst_valid_o, 1);
    check("t3_out_ready_full", bus.sfu_out_ready_o, 0);
    bus.job_len_i = 6'd4; tick();
    check("t3_ready_full", bus.job_ready_o, 0);
    inject = 1; tick();
    check("t3_overflow_sticky", bus.err_overflow_o, 1);
    dst_rdy_en = 1; repeat (3) tick(); dst_rdy_en = 0; tick();
    check("t3_popped3", n_dst, 3);
    check("t3_ready_free3", bus.job_ready_o, 0);
    dst_rdy_en = 1; tick(); dst_rdy_en = 0; tick();
    check("t3_ready_free4", bus.job_ready_o, 1);
    bus.job_len_i = 6'd5; tick();
    check("t3_ready_len5_free4", bus.job_ready_o, 0);
    bus.job_len_i = 6'd0;
    dst_rdy_en = 1;
    drain(200);
    check("t3_dst_beats", n_dst, 32);

    // Non-softmax func: no start pulse, busy ignored
    busy_force = 1;
    run_job(6'b000101, 6'd2, 500);
    drain(200);
    busy_force = 0;
    check("t4_start_count", n_start, 0);
    check("t4_in_beats", n_in, 2);
    check("t4_dst_beats", n_dst, 2);
    check("t4_done_count", n_done, 1);

    // Silent SFU: watchdog abort
    emit_en = 0;
    run_job(6'b010010, 6'd2, TO + 200);
    check("t5_timeout_flag", bus.err_timeout_o, 1);
    check("t5_timeout_cycles", end_cyc - last_in_cyc, TO);
    check("t5_no_done", n_done, 0);
    check("t5_overflow_kept", bus.err_overflow_o, 1);
    exp_q.delete(); sfu_q.delete(); sfu_due.delete();
    emit_en = 1;
    bus.job_len_i = 6'd4; tick();
    check("t5_ready_back", bus.job_ready_o, 1);
    bus.job_len_i = 6'd0;

    // Reset in the middle of FEED
    accepted = 0; n_in = 0;
    bus.job_func_i = 6'b010011; bus.job_len_i = 6'd32; bus.job_valid_i = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) tick();
    bus.job_valid_i = 1'b0; bus.job_len_i = 6'd0;
    for (int i = 0; i < 100 && n_in < 5; i++) tick();
    check("t6_reached_feed", n_in, 5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl_outputs", {bus.job_ready_o, bus.src_ready_o, bus.sfu_in_valid_o, bus.sfu_start_o,
                                  bus.done_o, bus.dst_valid_o, bus.err_overflow_o, bus.err_timeout_o}, 0);
    check("t6_rst_csr", bus.sfu_csr_o, 0);
    exp_q.delete(); sfu_q.delete(); sfu_due.delete(); busy_tail = 0;
    tick();
    check("t6_rst_edge_outputs", {bus.src_ready_o, bus.sfu_in_valid_o, bus.dst_valid_o,
                                  bus.err_overflow_o, bus.err_timeout_o}, 0);
    check("t6_rst_fifo_empty", bus.sfu_out_ready_o, 1);
    rst_n = 1'b1;
    exp_q.delete(); sfu_q.delete(); sfu_due.delete();
    tick();

    // Recovery with the minimum length
    run_job(6'b010011, 6'd1, 500);
    drain(200);
    check("t7_dst_beats", n_dst, 1);
    check("t7_done_count", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
